// File: rtl/counting_circuit.sv
// counting_circuit: counts synchronized rising edges of Ring_in over GATE_CYCLES-long clk windows.
// Optional feature macro COUNTING_CIRCUIT_SATURATE_EN: saturate the edge count at 8'hFF instead of wrapping.
module counting_circuit #(
    parameter int GATE_CYCLES = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Ring_in,
    output logic [7:0] value_out,
    output logic       value_valid
);

    localparam int                GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [GATE_W-1:0]      r_gate_cnt;
    logic [7:0]             r_edge_cnt;
    logic [7:0]             r_value;
    logic                   r_valid;
    logic                   w_edge;
    logic [7:0]             w_next_cnt;

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

    // The same next-count feeds both the running counter and the published value,
    // so an edge landing in the closing cycle is folded into the closing window.
`ifdef COUNTING_CIRCUIT_SATURATE_EN
    assign w_next_cnt = (r_edge_cnt == 8'hFF) ? 8'hFF : (r_edge_cnt + {7'd0, w_edge});
`else
    assign w_next_cnt = r_edge_cnt + {7'd0, w_edge};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_prev     <= 1'b0;
            r_gate_cnt <= '0;
            r_edge_cnt <= 8'h00;
            r_value    <= 8'h00;
            r_valid    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], Ring_in};
            r_prev <= r_sync[SYNC_STAGES-1];
            if (r_gate_cnt == GATE_LAST) begin
                r_gate_cnt <= '0;
                r_value    <= w_next_cnt;
                r_edge_cnt <= 8'h00;
                r_valid    <= 1'b1;
            end else begin
                r_gate_cnt <= r_gate_cnt + GATE_W'(1);
                r_edge_cnt <= w_next_cnt;
                r_valid    <= 1'b0;
            end
        end
    end

    assign value_out   = r_value;
    assign value_valid = r_valid;

endmodule

// File: tb/tb_counting_circuit.sv
// tb_counting_circuit: directed window-by-window vectors on a 16-cycle gate, plus an overflow run on a 1024-cycle gate.
module tb_counting_circuit;

    localparam int GATE     = 16;
    localparam int GATE_BIG = 1024;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ringIn  = 1'b0;
    logic       ringBig = 1'b0;
    logic [7:0] valueOut;
    logic [7:0] valueBig;
    logic       validOut;
    logic       validBig;

    int vectorsApplied = 0;
    int miscompares    = 0;

    typedef struct {
        int         offset;
        int         pulses;
        int         period;
        logic [7:0] expValue;
    } WindowVec;

    WindowVec vecs[8];

    always #5 clk = ~clk;

    counting_circuit #(.GATE_CYCLES(GATE), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Ring_in     (ringIn),
        .value_out   (valueOut),
        .value_valid (validOut)
    );

    counting_circuit #(.GATE_CYCLES(GATE_BIG), .SYNC_STAGES(2)) dutBig (
        .clk         (clk),
        .rst_n       (rst_n),
        .Ring_in     (ringBig),
        .value_out   (valueBig),
        .value_valid (validBig)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Entered at a negedge where the gate counter reads 0; drives one full window and
    // returns at the negedge where that window's strobe must be showing.
    task automatic applyStimulus(input int offset, input int pulses, input int period,
                                 input logic baseLevel, input logic [7:0] expValue,
                                 input string name);
        int early = 0;
        for (int g = 0; g < GATE; g++) begin
            if (g > 0 && validOut) early++;
            ringIn = baseLevel | ((g >= offset) && ((g - offset) / period < pulses)
                                 && ((g - offset) % period < period / 2));
            @(negedge clk);
        end
        checkOutput({name, " strobe"}, early * 2 + int'(validOut), 1);
        checkOutput({name, " value"}, int'(valueOut), int'(expValue));
    endtask

    initial begin
        int strobes;
        int cycles;
        logic [7:0] expBig;

        vecs[0] = '{0, 0, 2, 8'd0};
        vecs[1] = '{0, 1, 2, 8'd1};
        vecs[2] = '{0, 3, 2, 8'd3};
        vecs[3] = '{0, 7, 2, 8'd7};
        vecs[4] = '{0, 4, 4, 8'd4};
        vecs[5] = '{0, 2, 4, 8'd2};
        vecs[6] = '{0, 5, 2, 8'd5};
        vecs[7] = '{0, 1, 4, 8'd1};

        repeat (3) @(negedge clk);
        checkOutput("reset value", int'(valueOut), 0);
        checkOutput("reset valid", int'(validOut), 0);

        rst_n = 1'b1;
        for (int i = 0; i < 8; i++)
            applyStimulus(vecs[i].offset, vecs[i].pulses, vecs[i].period, 1'b0,
                          vecs[i].expValue, $sformatf("vec%0d", i));

        // An edge reaching the detector in the closing cycle stays in the closing window;
        // one cycle later it moves to the next window.
        applyStimulus(13, 1, 2, 1'b0, 8'd1, "boundaryClose");
        applyStimulus(0, 0, 2, 1'b0, 8'd0, "boundaryAfter");
        applyStimulus(14, 1, 2, 1'b0, 8'd0, "boundaryLate");
        applyStimulus(0, 0, 2, 1'b0, 8'd1, "boundaryCarry");

        for (int g = 0; g < 8; g++) begin
            ringIn = (g < 6) && (g % 2 == 0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midReset value", int'(valueOut), 0);
        checkOutput("midReset valid", int'(validOut), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 2, 2, 1'b0, 8'd2, "postReset");

        rst_n  = 1'b0;
        ringIn = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 2, 1'b1, 8'd1, "highRelease");
        applyStimulus(0, 0, 2, 1'b1, 8'd0, "highHold");
        ringIn = 1'b0;

        // One edge every two cycles gives 512 edges per full 1024-cycle window.
`ifdef COUNTING_CIRCUIT_SATURATE_EN
        expBig = 8'hFF;
`else
        expBig = 8'h00;
`endif
        strobes = 0;
        cycles  = 0;
        while (strobes < 3 && cycles < 4000) begin
            ringBig = ~ringBig;
            @(negedge clk);
            cycles++;
            if (validBig) strobes++;
        end
        checkOutput("overflow strobes", strobes, 3);
        checkOutput("overflow value", int'(valueBig), int'(expBig));

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
